// File: rtl/maze_tile_ram.sv
// Writable maze bitmap RAM with multi-port registered reads, bit writes, a reload sequencer and a live set-bit count.
// Optional write-to-read forwarding is enabled by defining MAZE_RAM_FWD_EN; the shadow ROM contents come from INIT_ROWS (row r at bits [r*DATA_WIDTH +: DATA_WIDTH]).
module maze_tile_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 24,
  parameter int NUM_READ   = 17,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_ROWS = '0,
  parameter int COL_W      = $clog2(DATA_WIDTH),
  parameter int CNT_W      = $clog2(DEPTH*DATA_WIDTH+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           reload_req,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [COL_W-1:0]               wr_col,
  input  logic                           wr_val,
  output logic                           wr_hit,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] r_data,
  output logic                           r_valid,
  output logic [CNT_W-1:0]               count,
  output logic                           empty
);

`ifdef MAZE_RAM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic {RELOAD, IDLE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]   wr_old;
  logic [DATA_WIDTH-1:0]   wr_new;
  logic                    wr_accept;
  logic                    wr_change;
  logic [DATA_WIDTH-1:0]   load_row;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_WIDTH-1:0] row);
    logic [CNT_W-1:0] pc;
    pc = '0;
    for (int b = 0; b < DATA_WIDTH; b++) pc = pc + CNT_W'(row[b]);
    return pc;
  endfunction

  assign busy      = (state == RELOAD);
  assign empty     = (count == '0) && !busy;
  assign load_row  = INIT_ROWS[int'(ptr)*DATA_WIDTH +: DATA_WIDTH];
  assign wr_old    = mem[wr_addr];
  assign wr_accept = (state == IDLE) && wr_en && !reload_req &&
                     (int'(wr_addr) < DEPTH) && (int'(wr_col) < DATA_WIDTH);
  assign wr_change = wr_accept && (wr_old[wr_col] != wr_val);

  always_comb begin
    wr_new         = wr_old;
    wr_new[wr_col] = wr_val;
  end

  // Rows past DEPTH read as solid wall; forwarding only applies to accepted writes.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (int'(r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) >= DEPTH)
        rd_next[i*DATA_WIDTH +: DATA_WIDTH] = '1;
      else if (FWD && wr_accept && (r_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr))
        rd_next[i*DATA_WIDTH +: DATA_WIDTH] = wr_new;
      else
        rd_next[i*DATA_WIDTH +: DATA_WIDTH] = mem[r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RELOAD;
      ptr     <= '0;
      count   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      wr_hit  <= 1'b0;
    end else begin
      r_data  <= rd_next;
      r_valid <= !busy;
      case (state)
        RELOAD: begin
          mem[ptr] <= load_row;
          count    <= count + popcount(load_row);
          wr_hit   <= 1'b0;
          if (int'(ptr) == DEPTH-1) state <= IDLE;
          else                      ptr   <= ptr + 1'b1;
        end
        IDLE: begin
          if (reload_req) begin
            state  <= RELOAD;
            ptr    <= '0;
            count  <= '0;
            wr_hit <= 1'b0;
          end else if (wr_en) begin
            wr_hit <= wr_change;
            if (wr_change) begin
              mem[wr_addr] <= wr_new;
              count        <= wr_val ? count + CNT_W'(1) : count - CNT_W'(1);
            end
          end
        end
        default: state <= RELOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_tile_ram.sv
// Directed bench for maze_tile_ram with a row-array reference model checked every cycle.
// Expectation for same-cycle read/write follows MAZE_RAM_FWD_EN.
module tb_maze_tile_ram;

  localparam int DW = 8, AW = 2, DEPTH = 3, NR = 2, COL_W = 3, CNT_W = 5;

`ifdef MAZE_RAM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, reload_req, wr_en, wr_val;
  logic [AW-1:0]     wr_addr;
  logic [COL_W-1:0]  wr_col;
  logic [NR*AW-1:0]  r_addr;
  logic [NR*DW-1:0]  r_data;
  logic              busy, wr_hit, r_valid, empty;
  logic [CNT_W-1:0]  count;

  maze_tile_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_READ(NR),
    .INIT_ROWS(24'h00_81_FF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reload_req(reload_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_col(wr_col), .wr_val(wr_val),
    .wr_hit(wr_hit), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  logic [7:0] init_rows [3] = '{8'hFF, 8'h81, 8'h00};
  logic [7:0] m_mem [3];
  bit         m_reloading;
  int         m_loaded;
  bit         m_hit, m_rvalid;
  logic [7:0] m_rd [2];
  bit         m_rd_known [2];
  int         checks = 0;
  int         errors = 0;

  function automatic int model_count();
    int n;
    n = 0;
    for (int r = 0; r < 3; r++)
      if (!m_reloading || r < m_loaded) n += $countones(m_mem[r]);
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    int mc;
    mc = model_count();
    check("busy", 32'(busy), 32'(m_reloading));
    check("count", 32'(count), mc);
    check("empty", 32'(empty), 32'(mc == 0 && !m_reloading));
    check("r_valid", 32'(r_valid), 32'(m_rvalid));
    check("wr_hit", 32'(wr_hit), 32'(m_hit));
    for (int i = 0; i < NR; i++)
      if (m_rd_known[i]) check("r_data", 32'(r_data[i*DW +: DW]), 32'(m_rd[i]));
  endtask

  // Advance one clock, update the model from the inputs held over that edge, then compare.
  task automatic applyStimulus();
    int a;
    bit wacc;
    logic [7:0] post;
    @(posedge clk);
    if (!rst_n) begin
      m_reloading = 1'b1;
      m_loaded    = 0;
      m_hit       = 1'b0;
      m_rvalid    = 1'b0;
      for (int i = 0; i < NR; i++) begin
        m_rd[i] = 8'h00;
        m_rd_known[i] = 1'b1;
      end
    end else begin
      wacc = !m_reloading && wr_en && !reload_req && (int'(wr_addr) < 3);
      post = 8'h00;
      if (wacc) begin
        post = m_mem[wr_addr];
        post[wr_col] = wr_val;
      end
      for (int i = 0; i < NR; i++) begin
        a = int'(r_addr[i*AW +: AW]);
        if (a >= 3)                                     m_rd[i] = 8'hFF;
        else if (FWD && wacc && a == int'(wr_addr))     m_rd[i] = post;
        else                                            m_rd[i] = m_mem[a];
        m_rd_known[i] = (a >= 3) || !m_reloading;
      end
      m_rvalid = !m_reloading;
      if (m_reloading) begin
        m_mem[m_loaded] = init_rows[m_loaded];
        m_loaded++;
        if (m_loaded == 3) m_reloading = 1'b0;
        m_hit = 1'b0;
      end else if (reload_req) begin
        m_reloading = 1'b1;
        m_loaded    = 0;
        m_hit       = 1'b0;
      end else if (wr_en) begin
        m_hit = wacc && (m_mem[wr_addr] != post);
        if (wacc) m_mem[wr_addr] = post;
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic set_write(input logic en, input int a, input int c, input logic v);
    wr_en   = en;
    wr_addr = AW'(a);
    wr_col  = COL_W'(c);
    wr_val  = v;
  endtask

  initial begin
    for (int r = 0; r < 3; r++) m_mem[r] = 8'h00;
    rst_n = 1'b0; reload_req = 1'b0;
    set_write(1'b0, 0, 0, 1'b0);
    r_addr = {2'd0, 2'd1};
    applyStimulus();
    applyStimulus();
    check("reset_busy", 32'(busy), 1);
    check("reset_rdata", 32'(r_data), 0);

    // Reload after release: three busy cycles, then idle with ten set bits
    rst_n = 1'b1;
    applyStimulus();
    applyStimulus();
    check("s1_busy_mid", 32'(busy), 1);
    applyStimulus();
    check("s1_busy_done", 32'(busy), 0);
    check("s1_count", 32'(count), 10);
    check("s1_empty", 32'(empty), 0);
    applyStimulus();
    check("s1_row1", 32'(r_data[7:0]), 32'h81);
    check("s1_valid", 32'(r_valid), 1);

    // Clear bit (1,0), then repeat the same write
    set_write(1'b1, 1, 0, 1'b0);
    applyStimulus();
    check("s2_hit", 32'(wr_hit), 1);
    check("s2_count", 32'(count), 9);
    set_write(1'b0, 0, 0, 1'b0);
    applyStimulus();
    check("s2_row1", 32'(r_data[7:0]), 32'h80);
    check("s2_hit_holds", 32'(wr_hit), 1);
    set_write(1'b1, 1, 0, 1'b0);
    applyStimulus();
    check("s2_rep_hit", 32'(wr_hit), 0);
    check("s2_rep_count", 32'(count), 9);

    // Out-of-range write and read
    set_write(1'b1, 3, 2, 1'b1);
    r_addr = {2'd3, 2'd1};
    applyStimulus();
    check("s3_count", 32'(count), 9);
    check("s3_wall", 32'(r_data[15:8]), 32'hFF);

    // Clear everything, then reload (a concurrent write is dropped)
    for (int c = 0; c < 8; c++) begin
      set_write(1'b1, 0, c, 1'b0);
      applyStimulus();
    end
    set_write(1'b1, 1, 7, 1'b0);
    applyStimulus();
    check("s4_count0", 32'(count), 0);
    check("s4_empty", 32'(empty), 1);
    set_write(1'b1, 2, 0, 1'b1);
    reload_req = 1'b1;
    r_addr = {2'd2, 2'd0};
    applyStimulus();
    reload_req = 1'b0;
    set_write(1'b0, 0, 0, 1'b0);
    check("s4_busy", 32'(busy), 1);
    check("s4_hit_clr", 32'(wr_hit), 0);
    for (int k = 0; k < 3; k++) applyStimulus();
    check("s4_idle", 32'(busy), 0);
    check("s4_count", 32'(count), 10);
    applyStimulus();
    check("s4_row0", 32'(r_data[7:0]), 32'hFF);
    check("s4_row2", 32'(r_data[15:8]), 32'h00);

    // Reset in the middle of a reload restarts it cleanly
    reload_req = 1'b1;
    applyStimulus();
    reload_req = 1'b0;
    applyStimulus();
    rst_n = 1'b0;
    applyStimulus();
    check("s5_rst_count", 32'(count), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus();
    check("s5_busy", 32'(busy), 0);
    check("s5_count", 32'(count), 10);

    // Same-cycle write and read of one row
    applyStimulus();
    set_write(1'b1, 2, 3, 1'b1);
    r_addr = {2'd0, 2'd2};
    applyStimulus();
    check("s6_same_cycle", 32'(r_data[7:0]), FWD ? 32'h08 : 32'h00);
    check("s6_count", 32'(count), 11);
    set_write(1'b0, 0, 0, 1'b0);
    applyStimulus();
    check("s6_next", 32'(r_data[7:0]), 32'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
